// File: rtl/plot_segment_emitter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// plot_segment_emitter_if : frame control, sample stream and line_drawer bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface plot_segment_emitter_if #(
  parameter int NUMBER_WIDTH = 16,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 9
);
  logic                    start;
  logic                    ready;
  logic [NUMBER_WIDTH-1:0] sample_value;
  logic                    sample_defined;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [X_WIDTH-1:0]      x1;
  logic [Y_WIDTH-1:0]      y1;
  logic [X_WIDTH-1:0]      x2;
  logic [Y_WIDTH-1:0]      y2;
  logic                    line_drawer_start;
  logic                    line_drawer_ready;

  modport master (
    output start, sample_value, sample_defined, sample_valid, line_drawer_ready,
    input  ready, sample_ready, x1, y1, x2, y2, line_drawer_start
  );

  modport slave (
    input  start, sample_value, sample_defined, sample_valid, line_drawer_ready,
    output ready, sample_ready, x1, y1, x2, y2, line_drawer_start
  );
endinterface
`default_nettype wire

// File: rtl/plot_segment_emitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// plot_segment_emitter : turns per-column samples into clipped line segments
// Revision 1.0
// ---------------------------------------------------------------------------
module plot_segment_emitter #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int HOR_ACTIVE_PIXELS     = 640,
  parameter int VER_ACTIVE_PIXELS     = 480,
  parameter int X_STEP                = 1,
  parameter int PIXELS_PER_UNIT_LOG2  = 4,
  parameter int Y_ORIGIN              = VER_ACTIVE_PIXELS / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  plot_segment_emitter_if.slave  bus
);
  localparam int NUMBER_WIDTH  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int CALC_WIDTH    = NUMBER_WIDTH + 2;
  localparam int X_WIDTH       = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH       = $clog2(VER_ACTIVE_PIXELS);
  localparam int FRAME_SAMPLES = (HOR_ACTIVE_PIXELS - 1) / X_STEP + 1;
  localparam int LAST_COL      = (FRAME_SAMPLES - 1) * X_STEP;
  localparam int SHIFT         = FRACTIONAL_PART_WIDTH - PIXELS_PER_UNIT_LOG2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCEPT  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]              state;
  logic [2:0]              state_next;
  logic [X_WIDTH-1:0]      col;
  logic [NUMBER_WIDTH-1:0] value_reg;
  logic                    defined_reg;
  logic [X_WIDTH-1:0]      prev_x;
  logic [Y_WIDTH-1:0]      prev_y;
  logic                    prev_above;
  logic                    prev_below;
  logic                    prev_valid;
  logic                    last_pending;
  logic                    wait_first;
  logic [X_WIDTH-1:0]      seg_x1;
  logic [Y_WIDTH-1:0]      seg_y1;
  logic [X_WIDTH-1:0]      seg_x2;
  logic [Y_WIDTH-1:0]      seg_y2;

  logic signed [CALC_WIDTH-1:0] value_ext;
  logic signed [CALC_WIDTH-1:0] row_full;
  logic                         row_above;
  logic                         row_below;
  logic [Y_WIDTH-1:0]           row_clamped;
  logic                         emit;
  logic                         is_last;

  // Row is computed two bits wider than the sample so that the origin offset cannot overflow.
  always_comb begin
    value_ext   = {{2{value_reg[NUMBER_WIDTH-1]}}, value_reg};
    row_full    = $signed(CALC_WIDTH'(Y_ORIGIN)) - (value_ext >>> SHIFT);
    row_above   = (row_full < 0);
    row_below   = (row_full > $signed(CALC_WIDTH'(VER_ACTIVE_PIXELS - 1)));
    row_clamped = row_full[Y_WIDTH-1:0];
    if (row_above) begin
      row_clamped = '0;
    end else if (row_below) begin
      row_clamped = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
    end
    emit    = prev_valid && defined_reg &&
              !(prev_above && row_above) && !(prev_below && row_below);
    is_last = (col == X_WIDTH'(LAST_COL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (bus.start) state_next = S_ACCEPT;
      S_ACCEPT:  if (bus.sample_valid) state_next = S_CONVERT;
      S_CONVERT: begin
        if (emit) begin
          state_next = S_ISSUE;
        end else if (is_last) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_ACCEPT;
        end
      end
      S_ISSUE:   if (bus.line_drawer_ready) state_next = S_WAIT;
      S_WAIT: begin
        // line_drawer may still report ready in the cycle right after start.
        if (!wait_first && bus.line_drawer_ready) begin
          state_next = last_pending ? S_IDLE : S_ACCEPT;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready             = (state == S_IDLE);
    bus.sample_ready      = (state == S_ACCEPT);
    bus.line_drawer_start = (state == S_ISSUE) && bus.line_drawer_ready;
    bus.x1                = seg_x1;
    bus.y1                = seg_y1;
    bus.x2                = seg_x2;
    bus.y2                = seg_y2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      value_reg    <= '0;
      defined_reg  <= 1'b0;
      prev_x       <= '0;
      prev_y       <= '0;
      prev_above   <= 1'b0;
      prev_below   <= 1'b0;
      prev_valid   <= 1'b0;
      last_pending <= 1'b0;
      wait_first   <= 1'b0;
      seg_x1       <= '0;
      seg_y1       <= '0;
      seg_x2       <= '0;
      seg_y2       <= '0;
    end else begin
      wait_first <= (state == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            col        <= '0;
            prev_valid <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.sample_valid) begin
            value_reg   <= bus.sample_value;
            defined_reg <= bus.sample_defined;
          end
        end
        S_CONVERT: begin
          if (emit) begin
            seg_x1 <= prev_x;
            seg_y1 <= prev_y;
            seg_x2 <= col;
            seg_y2 <= row_clamped;
          end
          prev_x       <= col;
          prev_y       <= row_clamped;
          prev_above   <= row_above;
          prev_below   <= row_below;
          prev_valid   <= defined_reg;
          last_pending <= is_last;
          if (!is_last) begin
            col <= col + X_WIDTH'(X_STEP);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_plot_segment_emitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_plot_segment_emitter : random frames vs. reference plotter, scoreboarded
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_plot_segment_emitter;
  typedef struct {
    int x1;
    int y1;
    int x2;
    int y2;
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plot_segment_emitter_if #(.NUMBER_WIDTH(16), .X_WIDTH(10), .Y_WIDTH(9)) bus_a ();
  plot_segment_emitter_if #(.NUMBER_WIDTH(16), .X_WIDTH(10), .Y_WIDTH(9)) bus_b ();

  plot_segment_emitter u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  plot_segment_emitter #(.X_STEP(4)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   vectors = 0;
  int   miscompares = 0;
  seg_t exp_q[$];
  seg_t got_q[$];
  logic [15:0] vals[640];
  bit   defs[640];
  bit   ld_force_low = 1'b0;
  int   ld_busy_max = 3;
  seg_t mon_e;
  seg_t mon_a;
  int   acc_b = 0;
  int   seg_b = 0;
  int   lx1_b = 0;
  int   lx2_b = 0;

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_seg(string name, seg_t a, int x1, int y1, int x2, int y2);
    vectors++;
    if (a.x1 != x1 || a.y1 != y1 || a.x2 != x2 || a.y2 != y2) begin
      miscompares++;
      $display("FAIL %s: got (%0d,%0d,%0d,%0d), expected (%0d,%0d,%0d,%0d)",
               name, a.x1, a.y1, a.x2, a.y2, x1, y1, x2, y2);
    end
  endtask

  // Reference plotter: every column mapped to a row with floor scaling, then clipped.
  function automatic void build_expected();
    int px, py, v, q, row, cr;
    bit pv, pa, pb, a, b;
    seg_t s;
    exp_q.delete();
    pv = 0; pa = 0; pb = 0; px = 0; py = 0;
    for (int k = 0; k < 640; k++) begin
      v   = int'($signed(vals[k]));
      q   = (v >= 0) ? v / 16 : -((-v + 15) / 16);
      row = 240 - q;
      a   = (row < 0);
      b   = (row > 479);
      cr  = a ? 0 : (b ? 479 : row);
      if (pv && defs[k] && !(pa && a) && !(pb && b)) begin
        s.x1 = px; s.y1 = py; s.x2 = k; s.y2 = cr;
        exp_q.push_back(s);
      end
      px = k; py = cr; pa = a; pb = b; pv = defs[k];
    end
  endfunction

  function automatic void fill_random();
    int t;
    for (int k = 0; k < 640; k++) begin
      defs[k] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        t = int'($urandom_range(0, 65535));
      end else begin
        t = int'($urandom_range(0, 8191)) - 4096;
      end
      vals[k] = 16'(t);
    end
  endfunction

  // Scoreboard monitor: pops one expected segment per line_drawer_start.
  always @(negedge clk) begin
    if (!rst && bus_a.line_drawer_start) begin
      mon_a.x1 = int'(bus_a.x1); mon_a.y1 = int'(bus_a.y1);
      mon_a.x2 = int'(bus_a.x2); mon_a.y2 = int'(bus_a.y2);
      got_q.push_back(mon_a);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL seg_unexpected: got (%0d,%0d,%0d,%0d), expected no segment",
                 mon_a.x1, mon_a.y1, mon_a.x2, mon_a.y2);
      end else begin
        mon_e = exp_q.pop_front();
        check_seg("segment", mon_a, mon_e.x1, mon_e.y1, mon_e.x2, mon_e.y2);
      end
    end
  end

  // line_drawer model: random busy period after each start.
  initial begin
    int  busy;
    bit  st;
    busy = 0;
    bus_a.line_drawer_ready = 1'b1;
    forever begin
      @(negedge clk);
      st = bus_a.line_drawer_start;
      @(posedge clk); #1;
      if (st) begin
        busy = int'($urandom_range(0, ld_busy_max));
      end else if (busy > 0) begin
        busy--;
      end
      bus_a.line_drawer_ready = !ld_force_low && (busy == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_b.sample_valid && bus_b.sample_ready) acc_b++;
    if (!rst && bus_b.line_drawer_start) begin
      seg_b++;
      lx1_b = int'(bus_b.x1);
      lx2_b = int'(bus_b.x2);
    end
  end

  task automatic feed(int k);
    int t;
    bit got;
    t = 0;
    got = 0;
    if ($urandom_range(0, 3) == 0) begin
      bus_a.sample_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus_a.sample_value   = vals[k];
    bus_a.sample_defined = defs[k];
    bus_a.sample_valid   = 1'b1;
    while (!got && t < 200) begin
      @(negedge clk);
      got = bus_a.sample_ready;
      @(posedge clk); #1;
      t++;
    end
    bus_a.sample_valid = 1'b0;
    if (!got) check("sample_accept_timeout", 0, 1);
  endtask

  task automatic start_frame();
    build_expected();
    got_q.delete();
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    @(negedge clk);
    check("ready_low_after_start", int'(bus_a.ready), 0);
    @(posedge clk); #1;
  endtask

  task automatic finish_frame(string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus_a.ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ready_returns"}, int'(bus_a.ready), 1);
    check({name, "_all_segments_seen"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(string name);
    start_frame();
    for (int k = 0; k < 640; k++) feed(k);
    finish_frame(name);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, t;
    bus_a.start = 1'b0; bus_a.sample_valid = 1'b0;
    bus_a.sample_value = '0; bus_a.sample_defined = 1'b0;
    bus_b.start = 1'b0; bus_b.sample_valid = 1'b1;
    bus_b.sample_value = '0; bus_b.sample_defined = 1'b1;
    bus_b.line_drawer_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(bus_a.ready), 1);
    check("reset_sample_ready", int'(bus_a.sample_ready), 0);
    check("reset_ld_start", int'(bus_a.line_drawer_start), 0);
    check("reset_coords", int'(bus_a.x1) + int'(bus_a.y1) + int'(bus_a.x2) + int'(bus_a.y2), 0);
    @(posedge clk); #1;

    // Flat zero line.
    for (int k = 0; k < 640; k++) begin vals[k] = 16'h0000; defs[k] = 1'b1; end
    run_frame("flat");
    check("flat_count", got_q.size(), 639);
    if (got_q.size() == 639) check_seg("flat_last", got_q[638], 638, 240, 639, 240);

    // Slope up then down.
    fill_random();
    vals[0] = 16'h0000; vals[1] = 16'h0100; vals[2] = 16'hFF00;
    defs[0] = 1'b1; defs[1] = 1'b1; defs[2] = 1'b1;
    run_frame("slope");
    if (got_q.size() >= 2) begin
      check_seg("slope_seg0", got_q[0], 0, 240, 1, 224);
      check_seg("slope_seg1", got_q[1], 1, 224, 2, 256);
    end else check("slope_count", got_q.size(), 2);

    // Both-above suppression and undefined gap.
    fill_random();
    vals[0] = 16'h7F00; vals[1] = 16'h7F00; vals[2] = 16'h0000;
    vals[4] = 16'h0000; vals[5] = 16'h0000;
    defs[0] = 1'b1; defs[1] = 1'b1; defs[2] = 1'b1; defs[3] = 1'b0;
    defs[4] = 1'b1; defs[5] = 1'b1;
    run_frame("clip_gap");
    if (got_q.size() >= 2) begin
      check_seg("clip_seg0", got_q[0], 1, 0, 2, 240);
      check_seg("gap_seg1", got_q[1], 4, 240, 5, 240);
    end else check("clip_gap_count", got_q.size(), 2);

    // line_drawer stalled for 20 cycles with a segment pending.
    fill_random();
    vals[0] = 16'h0000; vals[1] = 16'h0000; defs[0] = 1'b1; defs[1] = 1'b1;
    ld_force_low = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_frame();
    feed(0);
    feed(1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.line_drawer_start || bus_a.sample_ready) bad++;
    end
    check("stall_quiet_cycles", bad, 0);
    @(posedge clk); #1;
    ld_force_low = 1'b0;
    for (int k = 2; k < 640; k++) feed(k);
    finish_frame("stall");

    // Reset while waiting on line_drawer.
    fill_random();
    vals[0] = 16'h0200; vals[1] = 16'h0300; defs[0] = 1'b1; defs[1] = 1'b1;
    start_frame();
    feed(0);
    feed(1);
    t = 0;
    @(negedge clk);
    while (!bus_a.line_drawer_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_wait_seg_seen", int'(bus_a.line_drawer_start), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_ready", int'(bus_a.ready), 1);
    check("rst_wait_sample_ready", int'(bus_a.sample_ready), 0);
    check("rst_wait_ld_start", int'(bus_a.line_drawer_start), 0);
    check("rst_wait_coords", int'(bus_a.x1) + int'(bus_a.y1) + int'(bus_a.x2) + int'(bus_a.y2), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();

    // Fully random frame after recovery.
    fill_random();
    run_frame("random");

    // X_STEP = 4 instance: 160 samples per frame.
    acc_b = 0; seg_b = 0;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus_b.ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("step4_ready_returns", int'(bus_b.ready), 1);
    check("step4_samples", acc_b, 160);
    check("step4_segments", seg_b, 159);
    check("step4_last_x1", lx1_b, 632);
    check("step4_last_x2", lx2_b, 636);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
